// File: rtl/pool2x2_mc_pkg.sv
// Shared constants for the 2x2 multi-channel pooling block.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;
    localparam int   POOL_RND = 2;

    function automatic logic [15:0] even_width(input logic [15:0] w);
        return {w[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/pool2x2_mc_reduce.sv
// One-channel combine of two samples: max or widened sum.
module pool_reduce
    import pool_pkg::*;
#(
    parameter int IW     = 8,
    parameter int SIGNED = 0
) (
    input  logic          i_mode,
    input  logic [IW-1:0] i_a,
    input  logic [IW-1:0] i_b,
    output logic [IW:0]   o_y
);

    logic [IW:0] w_ax;
    logic [IW:0] w_bx;
    logic        w_a_gt;

    assign w_ax = {(SIGNED != 0) && i_a[IW-1], i_a};
    assign w_bx = {(SIGNED != 0) && i_b[IW-1], i_b};

    assign w_a_gt = (SIGNED != 0) ? ($signed(w_ax) > $signed(w_bx))
                                  : (w_ax > w_bx);

    assign o_y = (i_mode == POOL_AVG) ? (w_ax + w_bx)
                                      : (w_a_gt ? w_ax : w_bx);

endmodule

// File: rtl/pool2x2_mc.sv
// 2x2 stride-2 max/avg pooling over a raster pixel stream, CH channels wide.
module pool2x2_mc
    import pool_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int CH     = 4,
    parameter int MAXW   = 256,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                cfg_mode,
    input  logic [15:0]         cfg_in_width,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic                in_sof,
    input  logic [CH*DATAW-1:0] in_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [CH*DATAW-1:0] out_data,
    output logic                cfg_err
);

    localparam int PW    = CH * DATAW;
    localparam int BW    = CH * (DATAW + 1);
    localparam int SW    = DATAW + 2;
    localparam int DEPTH = MAXW / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]    r_col;
    logic           r_odd;
    logic           r_mode;
    logic [15:0]    r_inw;
    logic           r_err;
    logic [PW-1:0]  r_pend;
    logic [BW-1:0]  r_rd;
    logic           r_out_vld;
    logic [PW-1:0]  r_out_data;
    logic [BW-1:0]  r_mem [DEPTH];

    logic           w_acc;
    logic [15:0]    w_col;
    logic           w_odd;
    logic           w_latch;
    logic [15:0]    w_inw;
    logic [15:0]    w_w;
    logic           w_mode;
    logic           w_err;
    logic           w_use;
    logic           w_wr;
    logic           w_rdreq;
    logic           w_fire;
    logic           w_last;
    logic [AW-1:0]  w_addr;
    logic [BW-1:0]  w_pair;
    logic [CH*SW-1:0] w_sum;
    logic [PW-1:0]  w_res;

    assign in_rdy   = !r_out_vld || out_rdy;
    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign cfg_err  = r_err;

    // A start-of-frame pixel is treated as row 0, col 0 regardless of counters
    assign w_acc   = in_vld && in_rdy;
    assign w_col   = in_sof ? 16'd0 : r_col;
    assign w_odd   = in_sof ? 1'b0 : r_odd;
    assign w_latch = w_acc && !w_odd && (w_col == 16'd0);
    assign w_inw   = w_latch ? cfg_in_width : r_inw;
    assign w_mode  = w_latch ? cfg_mode : r_mode;
    assign w_w     = even_width(w_inw);
    assign w_err   = w_latch ? ((w_w < 16'd2) || (32'(w_w) > MAXW)) : r_err;

    assign w_use   = w_acc && !w_err && (w_col < w_w);
    assign w_wr    = w_use && !w_odd && w_col[0];
    assign w_rdreq = w_use && w_odd && !w_col[0];
    assign w_fire  = w_use && w_odd && w_col[0];
    assign w_addr  = w_col[AW:1];
    assign w_last  = ({1'b0, w_col} + 17'd1) >= {1'b0, w_inw};

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [SW-1:0] w_sum_k;

        pool_reduce #(.IW(DATAW), .SIGNED(SIGNED)) u_pair (
            .i_mode (w_mode),
            .i_a    (r_pend[k*DATAW +: DATAW]),
            .i_b    (in_data[k*DATAW +: DATAW]),
            .o_y    (w_pair[k*(DATAW+1) +: DATAW+1])
        );

        pool_reduce #(.IW(DATAW+1), .SIGNED(SIGNED)) u_final (
            .i_mode (w_mode),
            .i_a    (w_pair[k*(DATAW+1) +: DATAW+1]),
            .i_b    (r_rd[k*(DATAW+1) +: DATAW+1]),
            .o_y    (w_sum[k*SW +: SW])
        );

        assign w_sum_k = w_sum[k*SW +: SW];

        // Truncation makes logical and arithmetic shift identical here
        assign w_res[k*DATAW +: DATAW] = (w_mode == POOL_AVG)
            ? DATAW'((w_sum_k + SW'(POOL_RND)) >> 2)
            : w_sum_k[DATAW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_col      <= '0;
            r_odd      <= 1'b0;
            r_mode     <= POOL_MAX;
            r_inw      <= '0;
            r_err      <= 1'b0;
            r_pend     <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_acc) begin
                r_col  <= w_last ? 16'd0 : w_col + 16'd1;
                r_odd  <= w_last ? !w_odd : w_odd;
                r_mode <= w_mode;
                r_inw  <= w_inw;
                r_err  <= w_err;
                if (w_use && !w_col[0]) begin
                    r_pend <= in_data;
                end
            end
            if (w_fire) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_res;
            end else if (out_rdy) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    // Even rows write at odd columns, odd rows read at even columns
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_addr] <= w_pair;
        end else if (w_rdreq) begin
            r_rd <= r_mem[w_addr];
        end
    end

endmodule

// File: tb/tb_pool2x2_mc.sv
// Bench for pool2x2_mc: unsigned and signed instances fed the same stream.
module tb_pool2x2_mc;
    import pool_pkg::*;

    localparam int DW   = 8;
    localparam int CH   = 4;
    localparam int MAXW = 16;
    localparam int PW   = DW * CH;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [15:0]   cfg_in_width = 16'd2;
    logic          in_vld = 1'b0;
    logic          in_sof = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_rdy = 1'b1;
    logic          u_in_rdy, u_out_vld, u_cfg_err;
    logic          s_in_rdy, s_out_vld, s_cfg_err;
    logic [PW-1:0] u_out_data, s_out_data;

    always #5 clk = ~clk;

    pool2x2_mc #(.DATAW(DW), .CH(CH), .MAXW(MAXW), .SIGNED(0)) u_dut (
        .clk(clk), .rst_b(rst_b), .cfg_mode(cfg_mode),
        .cfg_in_width(cfg_in_width), .in_vld(in_vld), .in_rdy(u_in_rdy),
        .in_sof(in_sof), .in_data(in_data), .out_vld(u_out_vld),
        .out_rdy(out_rdy), .out_data(u_out_data), .cfg_err(u_cfg_err)
    );

    pool2x2_mc #(.DATAW(DW), .CH(CH), .MAXW(MAXW), .SIGNED(1)) s_dut (
        .clk(clk), .rst_b(rst_b), .cfg_mode(cfg_mode),
        .cfg_in_width(cfg_in_width), .in_vld(in_vld), .in_rdy(s_in_rdy),
        .in_sof(in_sof), .in_data(in_data), .out_vld(s_out_vld),
        .out_rdy(out_rdy), .out_data(s_out_data), .cfg_err(s_cfg_err)
    );

    int n_tests = 0;
    int n_fail = 0;
    bit rand_rdy = 1'b0;

    logic [PW-1:0] ex_u[$], ex_s[$], rx_u[$], rx_s[$];

    int            m_col, m_inw, m_w;
    bit            m_odd, m_mode, m_err;
    logic [PW-1:0] m_row0[MAXW];
    logic [PW-1:0] m_prev;

    typedef struct {
        bit mode;
        bit sgn;
        int inw;
        int r0[5];
        int r1[5];
        int nexp;
        int e[2];
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window result from the four samples, plain integer arithmetic
    function automatic logic [PW-1:0] pool4(input bit sgn, input bit mode,
        input logic [PW-1:0] a, input logic [PW-1:0] b,
        input logic [PW-1:0] c, input logic [PW-1:0] d);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            logic [7:0] t[4];
            int v[4];
            int acc;
            t[0] = a[k*8 +: 8];
            t[1] = b[k*8 +: 8];
            t[2] = c[k*8 +: 8];
            t[3] = d[k*8 +: 8];
            for (int j = 0; j < 4; j++)
                v[j] = sgn ? int'($signed(t[j])) : int'(t[j]);
            if (mode) begin
                acc = (v[0] + v[1] + v[2] + v[3] + 2) >>> 2;
            end else begin
                acc = v[0];
                for (int j = 1; j < 4; j++)
                    if (v[j] > acc) acc = v[j];
            end
            r[k*8 +: 8] = acc[7:0];
        end
        return r;
    endfunction

    task automatic model_push(input logic [PW-1:0] d, input bit sof);
        if (sof) begin
            m_col = 0;
            m_odd = 1'b0;
        end
        if (!m_odd && m_col == 0) begin
            m_mode = cfg_mode;
            m_inw  = int'(cfg_in_width);
            m_w    = m_inw & ~1;
            m_err  = (m_w < 2) || (m_w > MAXW);
        end
        if (!m_err && m_col < m_w) begin
            if (!m_odd) begin
                m_row0[m_col] = d;
            end else if (m_col % 2 == 1) begin
                ex_u.push_back(pool4(1'b0, m_mode, m_row0[m_col-1],
                                     m_row0[m_col], m_prev, d));
                ex_s.push_back(pool4(1'b1, m_mode, m_row0[m_col-1],
                                     m_row0[m_col], m_prev, d));
            end
            m_prev = d;
        end
        if (m_col + 1 >= m_inw) begin
            m_col = 0;
            m_odd = !m_odd;
        end else begin
            m_col++;
        end
    endtask

    task automatic clear_q();
        ex_u.delete();
        ex_s.delete();
        rx_u.delete();
        rx_s.delete();
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (u_out_vld && out_rdy) rx_u.push_back(u_out_data);
            if (s_out_vld && out_rdy) rx_s.push_back(s_out_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic do_reset();
        in_vld = 1'b0;
        in_sof = 1'b0;
        rst_b  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        m_col = 0;
        m_odd = 1'b0;
        m_err = 1'b0;
        clear_q();
        chk("rst_out_vld", 32'(u_out_vld), 0);
        chk("rst_out_data", u_out_data, 0);
        chk("rst_cfg_err", 32'(u_cfg_err), 0);
        chk("rst_in_rdy", 32'(u_in_rdy), 1);
        chk("rst_s_out_vld", 32'(s_out_vld), 0);
        chk("rst_s_cfg_err", 32'(s_cfg_err), 0);
    endtask

    task automatic send(input logic [PW-1:0] d, input bit sof);
        int n;
        n = 0;
        in_data = d;
        in_sof  = sof;
        in_vld  = 1'b1;
        @(negedge clk);
        while (!u_in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_rdy_timeout: got 0 expected 1");
        end else begin
            model_push(d, sof);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
        chk("cfg_err_u", 32'(u_cfg_err), 32'(m_err));
        chk("cfg_err_s", 32'(s_cfg_err), 32'(m_err));
    endtask

    task automatic drain_check(input string name);
        int n;
        n = 0;
        while ((rx_u.size() < ex_u.size() || rx_s.size() < ex_s.size())
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_cnt_u"}, 32'(rx_u.size()), 32'(ex_u.size()));
        chk({name, "_cnt_s"}, 32'(rx_s.size()), 32'(ex_s.size()));
        for (int i = 0; i < ex_u.size() && i < rx_u.size(); i++)
            chk({name, "_u"}, rx_u[i], ex_u[i]);
        for (int i = 0; i < ex_s.size() && i < rx_s.size(); i++)
            chk({name, "_s"}, rx_s[i], ex_s[i]);
        clear_q();
    endtask

    initial begin
        logic [PW-1:0] held;
        logic [PW-1:0] px;
        logic [PW-1:0] got;
        vt[0]  = '{mode:0, sgn:0, inw:4, r0:'{1,9,3,4,0},
                   r1:'{5,2,8,7,0}, nexp:2, e:'{9,8}};
        vt[1]  = '{mode:1, sgn:0, inw:2, r0:'{1,2,0,0,0},
                   r1:'{3,4,0,0,0}, nexp:1, e:'{3,0}};
        vt[2]  = '{mode:1, sgn:0, inw:2, r0:'{255,255,0,0,0},
                   r1:'{255,255,0,0,0}, nexp:1, e:'{255,0}};
        vt[3]  = '{mode:1, sgn:1, inw:2, r0:'{-1,-2,0,0,0},
                   r1:'{-3,-4,0,0,0}, nexp:1, e:'{254,0}};
        vt[4]  = '{mode:0, sgn:1, inw:2, r0:'{-1,-2,0,0,0},
                   r1:'{-3,-4,0,0,0}, nexp:1, e:'{255,0}};
        vt[5]  = '{mode:0, sgn:1, inw:2, r0:'{128,127,0,0,0},
                   r1:'{1,255,0,0,0}, nexp:1, e:'{127,0}};
        vt[6]  = '{mode:0, sgn:0, inw:2, r0:'{128,127,0,0,0},
                   r1:'{1,255,0,0,0}, nexp:1, e:'{255,0}};
        vt[7]  = '{mode:1, sgn:0, inw:4, r0:'{10,20,30,40,0},
                   r1:'{50,60,70,80,0}, nexp:2, e:'{35,55}};
        vt[8]  = '{mode:1, sgn:1, inw:2, r0:'{-1,-1,0,0,0},
                   r1:'{-1,0,0,0,0}, nexp:1, e:'{255,0}};
        vt[9]  = '{mode:0, sgn:0, inw:5, r0:'{1,2,3,4,99},
                   r1:'{5,6,7,8,200}, nexp:2, e:'{6,8}};
        vt[10] = '{mode:1, sgn:1, inw:2, r0:'{1,2,0,0,0},
                   r1:'{-1,-4,0,0,0}, nexp:1, e:'{0,0}};

        do_reset();

        // Directed windows, one sample replicated on every channel
        out_rdy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cfg_mode     = vt[i].mode;
            cfg_in_width = 16'(vt[i].inw);
            for (int c = 0; c < vt[i].inw; c++)
                send({CH{8'(vt[i].r0[c])}}, c == 0);
            for (int c = 0; c < vt[i].inw; c++)
                send({CH{8'(vt[i].r1[c])}}, 1'b0);
            repeat (4) @(negedge clk);
            chk($sformatf("vec%0d_cnt", i),
                32'(vt[i].sgn ? rx_s.size() : rx_u.size()),
                32'(vt[i].nexp));
            for (int j = 0; j < vt[i].nexp; j++) begin
                got = vt[i].sgn ? rx_s[j] : rx_u[j];
                chk($sformatf("vec%0d_out%0d", i, j), got,
                    {CH{8'(vt[i].e[j])}});
            end
            clear_q();
        end

        // Output held under backpressure
        cfg_mode     = POOL_MAX;
        cfg_in_width = 16'd2;
        out_rdy      = 1'b0;
        send(32'h01020304, 1'b1);
        send(32'h10203040, 1'b0);
        send(32'h05060708, 1'b0);
        send(32'h0a0b0c0d, 1'b0);
        held    = 32'h7f001122;
        in_data = held;
        in_sof  = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_vld", 32'(u_out_vld), 1);
            chk("bp_in_rdy", 32'(u_in_rdy), 0);
            chk("bp_out_data", u_out_data, 32'h10203040);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        send(held, 1'b1);
        send(32'h01010101, 1'b0);
        send(32'h02020202, 1'b0);
        send(32'h03030303, 1'b0);
        repeat (3) @(negedge clk);
        if (rx_u.size() > 0) chk("bp_first", rx_u[0], 32'h10203040);
        else chk("bp_first_cnt", 0, 1);
        drain_check("bp");

        // Illegal widths: everything swallowed, cfg_err up
        cfg_in_width = 16'd0;
        for (int i = 0; i < 4; i++) send(32'($urandom), i == 0);
        chk("w0_cfg_err", 32'(u_cfg_err), 1);
        cfg_in_width = 16'(MAXW + 2);
        for (int i = 0; i < 2 * (MAXW + 2); i++)
            send(32'($urandom), i == 0);
        chk("wbig_cfg_err", 32'(u_cfg_err), 1);
        drain_check("badw");

        // Frame restart in the middle of an odd row
        cfg_mode     = POOL_AVG;
        cfg_in_width = 16'd4;
        for (int i = 0; i < 6; i++) send(32'($urandom), i == 0);
        cfg_in_width = 16'd2;
        send(32'h04030201, 1'b1);
        send(32'h08070605, 1'b0);
        send(32'h0c0b0a09, 1'b0);
        send(32'h100f0e0d, 1'b0);
        repeat (3) @(negedge clk);
        if (rx_u.size() == 2) chk("sof_out", rx_u[1], 32'h0a090807);
        else chk("sof_cnt", 32'(rx_u.size()), 2);
        drain_check("sof");

        // Random frames with random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int rows;
            cfg_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                cfg_in_width = 16'($urandom_range(0, MAXW + 3));
            else
                cfg_in_width = 16'($urandom_range(2, MAXW + 1));
            rows = $urandom_range(1, 4);
            for (int p = 0; p < rows * int'(cfg_in_width) + 1; p++) begin
                px = 32'($urandom);
                send(px, p == 0 || $urandom_range(0, 60) == 0);
            end
            drain_check("rand");
            if ($urandom_range(0, 7) == 0) begin
                for (int p = 0; p < 3; p++) send(32'($urandom), p == 0);
                drain_check("rand_pre_rst");
                do_reset();
            end
        end
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
